// File: rtl/ble_rx_pkg.sv
// Shared types and constants for the BLE receive scan/capture path.
// No logic; next_adv_ch gives the advertising-channel hop order.
package ble_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOP     = 2'd1,
        LISTEN  = 2'd2,
        CAPTURE = 2'd3
    } scan_state_t;

    localparam logic [5:0] CH_ADV0 = 6'd37;
    localparam logic [5:0] CH_ADV1 = 6'd38;
    localparam logic [5:0] CH_ADV2 = 6'd39;

    localparam logic [6:0] PDU_HDR_BYTES = 7'd2;
    localparam logic [6:0] PDU_CRC_BYTES = 7'd3;
    localparam logic [5:0] PDU_LEN_MASK  = 6'h3F;

    function automatic logic [5:0] next_adv_ch(input logic [5:0] ch);
        case (ch)
            CH_ADV0: return CH_ADV1;
            CH_ADV1: return CH_ADV2;
            default: return CH_ADV0;
        endcase
    endfunction

endpackage

// File: rtl/ble_rx_deser.sv
// Symbol deserialiser: strobe edge detect, LSB-first byte shifter, symbol timeout.
// Latency: byte_done/byte_val are combinational in the cycle of the 8th strobe.
// Backpressure: none; the caller must sample byte_val in the byte_done cycle.
module ble_rx_deser #(
    parameter int SYM_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       active,
    input  logic       demod_symbol,
    input  logic       demod_symbol_clk,
    output logic       byte_done,
    output logic [7:0] byte_val,
    output logic       timeout
);

    localparam int TO_W = $clog2(SYM_TIMEOUT + 1);

    logic            sym_clk_q;
    logic            sym_stb;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;
    logic [TO_W-1:0] to_cnt;

    assign sym_stb   = demod_symbol_clk & ~sym_clk_q;
    assign byte_val  = {demod_symbol, shreg[7:1]};
    assign byte_done = active & sym_stb & (bit_cnt == 3'd7);
    assign timeout   = active & ~sym_stb & (to_cnt == TO_W'(SYM_TIMEOUT - 1));

    // Edge detector runs continuously so a strobe right after capture entry is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_clk_q <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            sym_clk_q <= demod_symbol_clk;
            if (!run) begin
                shreg   <= '0;
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else if (active) begin
                if (sym_stb) begin
                    shreg   <= byte_val;
                    bit_cnt <= bit_cnt + 3'd1;
                    to_cnt  <= '0;
                end else begin
                    to_cnt  <= to_cnt + TO_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ble_rx_scan_ctrl.sv
// BLE advertising scan FSM with packet capture into a one-entry byte holding register.
// Latency: all outputs registered; a completed byte is valid the cycle after its 8th strobe.
// Backpressure: byte_ready low holds the byte; bytes completing while it is held are dropped (overflow).
module ble_rx_scan_ctrl
    import ble_rx_pkg::*;
#(
    parameter int DWELL_CYCLES = 160000,
    parameter int SYM_TIMEOUT  = 64,
    parameter int DWELL_W      = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       hold_req,
    input  logic       demod_symbol,
    input  logic       demod_symbol_clk,
    input  logic       packet_detected,
    output logic [5:0] channel,
    output logic       cdr_en,
    output logic       cdr_clear,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       byte_last,
    output logic       pkt_start,
    output logic       pkt_done,
    output logic       overflow
);

    scan_state_t        state_q, state_nxt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               pd_q;
    logic               pd_rise;
    logic               dwell_exp;
    logic [6:0]         byte_cnt;
    logic [6:0]         total_bytes;
    logic               last_byte;
    logic               start_ev;
    logic               byte_done;
    logic [7:0]         byte_val;
    logic               timeout;

    assign pd_rise   = packet_detected & ~pd_q;
    assign dwell_exp = ~hold_req & (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1));
    assign last_byte = (byte_cnt >= PDU_HDR_BYTES) && (byte_cnt == total_bytes - 7'd1);
    assign start_ev  = (state_q == LISTEN) && (state_nxt == CAPTURE);

    ble_rx_deser #(.SYM_TIMEOUT(SYM_TIMEOUT)) u_deser (
        .clk              (clk),
        .rst_n            (rst_n),
        .run              (state_nxt == CAPTURE),
        .active           (state_q == CAPTURE),
        .demod_symbol     (demod_symbol),
        .demod_symbol_clk (demod_symbol_clk),
        .byte_done        (byte_done),
        .byte_val         (byte_val),
        .timeout          (timeout)
    );

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (en) state_nxt = HOP;
            HOP:     state_nxt = LISTEN;
            LISTEN:  if (pd_rise) state_nxt = CAPTURE;
                     else if (dwell_exp) state_nxt = HOP;
            CAPTURE: if ((byte_done && last_byte) || timeout) state_nxt = HOP;
            default: state_nxt = IDLE;
        endcase
        if (!en) state_nxt = IDLE;
    end

    // Outputs are derived from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pd_q      <= 1'b0;
            dwell_cnt <= '0;
            channel   <= CH_ADV0;
            cdr_en    <= 1'b0;
            cdr_clear <= 1'b0;
            pkt_start <= 1'b0;
            pkt_done  <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            pd_q      <= packet_detected;
            if (state_q == LISTEN && state_nxt == LISTEN)
                dwell_cnt <= hold_req ? dwell_cnt : dwell_cnt + DWELL_W'(1);
            else
                dwell_cnt <= '0;
            if (state_nxt == HOP)
                channel <= (state_q == IDLE) ? CH_ADV0 : next_adv_ch(channel);
            cdr_en    <= (state_nxt != IDLE);
            cdr_clear <= (state_nxt == HOP);
            pkt_start <= start_ev;
            pkt_done  <= en && (state_q == CAPTURE) && byte_done && last_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= '0;
            total_bytes <= '0;
        end else if (state_nxt != CAPTURE) begin
            byte_cnt    <= '0;
            total_bytes <= '0;
        end else if (byte_done) begin
            byte_cnt <= byte_cnt + 7'd1;
            if (byte_cnt == 7'd1)
                total_bytes <= PDU_HDR_BYTES + {1'b0, byte_val[5:0] & PDU_LEN_MASK} + PDU_CRC_BYTES;
        end
    end

    // A drain in the same cycle frees the slot, so the completing byte is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_last  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (!en) begin
                byte_valid <= 1'b0;
                byte_data  <= '0;
                byte_last  <= 1'b0;
            end else if (byte_done && (!byte_valid || byte_ready)) begin
                byte_valid <= 1'b1;
                byte_data  <= byte_val;
                byte_last  <= last_byte;
            end else if (byte_valid && byte_ready) begin
                byte_valid <= 1'b0;
                byte_data  <= '0;
                byte_last  <= 1'b0;
            end
            if (start_ev)
                overflow <= 1'b0;
            else if (en && byte_done && byte_valid && !byte_ready)
                overflow <= 1'b1;
        end
    end

endmodule

// File: doc/ble_rx_scan_ctrl.md
# ble_rx_scan_ctrl

Scan and capture controller for the BLE receiver datapath. It drives the CDR core's channel select and enable. It hops across the three advertising channels with a programmable dwell time. When the core raises packet detection, it switches to capture: it deserialises recovered symbols into bytes, parses the PDU length, and streams the bytes out over a valid/ready interface. It sits between the CDR core and the output/readout logic in the top-level wrapper.

## Interface
Parameters:
- `DWELL_CYCLES`, default 160000: clocks spent listening on each channel (10 ms at 16 MHz).
- `SYM_TIMEOUT`, default 64: clocks with no symbol strobe before a capture is aborted.
- `DWELL_W`, default 20: width of the dwell counter; must satisfy `DWELL_CYCLES < 2**DWELL_W`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: master enable, already synchronised.
- `hold_req` in 1: while high, dwell counting is frozen and hopping stops.
- `demod_symbol` in 1: recovered bit from the CDR.
- `demod_symbol_clk` in 1: symbol clock from the CDR; its rising edge marks a new valid bit.
- `packet_detected` in 1: access-address match, a level signal; its rising edge starts a capture.
- `channel` out 6: BLE channel index sent to the CDR.
- `cdr_en` out 1: enable to the CDR core.
- `cdr_clear` out 1: single-cycle pulse on every channel change.
- `byte_data` out 8: captured byte, LSB received first.
- `byte_valid` out 1, `byte_ready` in 1: output handshake.
- `byte_last` out 1: qualifies the final byte (last CRC byte).
- `pkt_start` out 1, `pkt_done` out 1: single-cycle status pulses.
- `overflow` out 1: sticky flag; cleared on the next `pkt_start`.

## Operation
- States: `IDLE`, `HOP`, `LISTEN`, `CAPTURE`.
- `IDLE`:
  - `cdr_en=0`.
  - When `en=1`, go to `HOP`.
- `HOP` (exactly 1 cycle):
  - `channel` advances 37→38→39→37. The first hop after `IDLE` selects 37.
  - `cdr_clear=1`, `cdr_en=1`.
  - Always goes to `LISTEN`.
- `LISTEN`:
  - The dwell counter starts at 0 and increments each cycle unless `hold_req=1`.
  - A rising edge on `packet_detected` → `CAPTURE` and `pkt_start` pulses.
  - Otherwise, when the counter reaches `DWELL_CYCLES-1` → `HOP`.
  - If a `packet_detected` edge and dwell expiry occur in the same cycle, capture wins.
- `CAPTURE`:
  - Symbol strobe: `sym_stb = demod_symbol_clk & ~prev`, where `prev` is a registered copy of `demod_symbol_clk`.
  - Bits are counted from the first strobe strictly after the detect cycle. Each strobe shifts `demod_symbol` into the MSB of an 8-bit shifter.
  - Every 8th strobe completes a byte.
  - Byte index 1 (the second header byte) supplies `len = byte[5:0]`.
  - Total bytes = `2 + len + 3`, at most 68, held in a 7-bit counter.
  - After the last byte is loaded, `pkt_done` pulses and the FSM goes to `HOP`.
- Capture abort: `SYM_TIMEOUT` clocks without a strobe →
  - the partial byte is discarded;
  - no `pkt_done` pulse;
  - any byte already in the holding register is kept;
  - the FSM goes to `HOP`.
- Output holding register (1 entry):
  - A completed byte loads the register and sets `byte_valid`.
  - The register clears on `byte_valid & byte_ready`.
  - If a byte completes while the register is full and not being drained in the same cycle, the new byte is dropped and `overflow` is set.
  - If the register drains and a new byte completes in the same cycle, the new byte is loaded with no overflow.
- Disable: `en=0` in any state forces `IDLE` on the next edge.
  - The shifter, the counters and the holding register are cleared.
  - `byte_valid` drops.
  - `channel` holds its value.

## Timing
Reset values:
- `channel=37`.
- `cdr_en=0`, `cdr_clear=0`.
- `byte_data=0`, `byte_valid=0`, `byte_last=0`.
- `pkt_start=0`, `pkt_done=0`, `overflow=0`.
- FSM in `IDLE`, all counters 0.

Latencies:
- All outputs are registered.
- `en` rise → `HOP` cycle (`cdr_clear=1`, `channel=37`) 1 cycle later.
- `packet_detected` edge cycle → `pkt_start` high on the next cycle.
- 8th strobe of a byte → `byte_valid` high on the next cycle.
- `pkt_done` and the last `byte_valid` rise in the same cycle, with `byte_last=1`.
- `byte_data` and `byte_last` are held stable while `byte_valid=1 & byte_ready=0`.

Dwell and reset:
- Dwell expiry: `LISTEN` lasts exactly `DWELL_CYCLES` cycles when `hold_req=0`.
- Asserting `rst_n=0` mid-capture returns every output to its reset value immediately (asynchronously).

## Structure
- Shared package `ble_rx_pkg`:
  - state enum `scan_state_t`;
  - advertising channel constants `CH_ADV0/1/2 = 37/38/39`;
  - `PDU_HDR_BYTES=2`, `PDU_CRC_BYTES=3`, `PDU_LEN_MASK=6'h3F`.
- One sub-module, `ble_rx_deser`: symbol edge detect, 8-bit shifter, bit counter, timeout counter. It outputs `byte_done` and `byte_val`.
- The FSM, channel sequencing and output holding register live in the top of this block.

## Test plan
- Reset, then `en=1`, `hold_req=0`, `DWELL_CYCLES=100`, no packet → `cdr_clear` pulses every 101 cycles; `channel` sequence is 37, 38, 39, 37.
- In `LISTEN` on 38, raise `packet_detected`, then feed bytes 0x40, 0x02, 0xAA, 0x55, 0x11, 0x22, 0x33 with `byte_ready=1` → 7 bytes out in order; `byte_last` and `pkt_done` on 0x33; next channel is 39.
- Same packet with `byte_ready=0` throughout → first byte (0x40) held stable on `byte_data`; `overflow=1`; no further bytes accepted.
- Stop strobes after 12 bits of a capture → abort after 64 cycles; no `pkt_done`; byte 0 still valid; `HOP` follows.
- Raise `packet_detected` in the same cycle the dwell counter expires → capture on the current channel, no hop.
- Drop `en` or pulse `rst_n` mid-capture → `IDLE`, `byte_valid=0`; on `rst_n`, `channel=37`.
